// File: rtl/up_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : up_bus_arbiter_if
// Purpose  : Requester handshake signals and microprocessor bus outputs of the
//            up_bus_arbiter. The bidirectional data bus is a plain port on the
//            arbiter, so tristate resolution happens at a module boundary.
// Revision : 1.0  initial release
// ============================================================================
interface up_bus_arbiter_if;
  // Requester 0
  logic       req0;
  logic       rw0;
  logic [5:0] addr0;
  logic [7:0] wdata0;
  logic       ack0;
  // Requester 1
  logic       req1;
  logic       rw1;
  logic [5:0] addr1;
  logic [7:0] wdata1;
  logic       ack1;
  // Shared status / read return
  logic [7:0] rdata;
  logic       busy;
  // Microprocessor bus control
  logic [5:0] uP_addr;
  logic       uP_cs_n;
  logic       uP_rw;

  // Arbiter side
  modport master (
    input  req0, rw0, addr0, wdata0,
    input  req1, rw1, addr1, wdata1,
    output ack0, ack1, rdata, busy,
    output uP_addr, uP_cs_n, uP_rw
  );

  // Requester / bus-observer side
  modport slave (
    output req0, rw0, addr0, wdata0,
    output req1, rw1, addr1, wdata1,
    input  ack0, ack1, rdata, busy,
    input  uP_addr, uP_cs_n, uP_rw
  );
endinterface
`default_nettype wire

// File: rtl/up_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : up_bus_arbiter
// Purpose  : Round-robin arbiter and phase sequencer for the 8-bit uP bus.
//            Each transfer walks SETUP -> ENABLE -> STROBE -> HOLD -> RECOV,
//            every phase timed by a down-counter loaded with its cycle count.
// Revision : 1.0  initial release
// ============================================================================
module up_bus_arbiter #(
  parameter int SETUP_CYC = 2,
  parameter int OE_CYC    = 1,
  parameter int CS_CYC    = 5,
  parameter int HOLD_CYC  = 1,
  parameter int RECOV_CYC = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  up_bus_arbiter_if.master bus,
  inout  wire logic [7:0]  uP_data
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_RECOV  = 3'd5
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rrPtr;     // requester that wins a tie next
  logic          r_owner;     // requester owning the current transfer
  logic          r_isRead;
  logic          r_dataOe;
  logic          r_csN;
  logic          r_upRw;
  logic [5:0]    r_upAddr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_rdSample;
  logic [7:0]    r_rdata;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_busy;

  logic          w_last;
  logic          w_arbPoint;
  logic          w_anyReq;
  logic          w_pick1;

  // Current phase ends on this edge.
  assign w_last     = (r_cnt == CW'(1));
  // The closing RECOV edge doubles as the IDLE decision point, so a waiting
  // requester is granted without an extra dead cycle between transfers.
  assign w_arbPoint = (r_state == S_IDLE) || ((r_state == S_RECOV) && w_last);
  assign w_anyReq   = bus.req0 | bus.req1;
  // Requester 1 wins when it is alone or when both ask and it holds priority.
  assign w_pick1    = bus.req1 & (~bus.req0 | r_rrPtr);

  // Phase sequencer, arbitration and all registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rrPtr    <= 1'b0;
      r_owner    <= 1'b0;
      r_isRead   <= 1'b0;
      r_dataOe   <= 1'b0;
      r_csN      <= 1'b1;
      r_upRw     <= 1'b1;
      r_upAddr   <= '0;
      r_wdata    <= '0;
      r_rdSample <= '0;
      r_rdata    <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;

      case (r_state)
        S_IDLE: begin
        end
        S_SETUP: begin
          if (w_last) begin
            r_state  <= S_ENABLE;
            r_cnt    <= CW'(OE_CYC);
            r_dataOe <= ~r_isRead;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_ENABLE: begin
          if (w_last) begin
            r_state <= S_STROBE;
            r_cnt   <= CW'(CS_CYC);
            r_csN   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_STROBE: begin
          if (w_last) begin
            r_state <= S_HOLD;
            r_cnt   <= CW'(HOLD_CYC);
            r_csN   <= 1'b1;
            if (r_isRead) r_rdSample <= uP_data;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_HOLD: begin
          if (w_last) begin
            r_state  <= S_RECOV;
            r_cnt    <= CW'(RECOV_CYC);
            r_upAddr <= '0;
            r_upRw   <= 1'b1;
            r_dataOe <= 1'b0;
            r_ack0   <= ~r_owner;
            r_ack1   <= r_owner;
            if (r_isRead) r_rdata <= r_rdSample;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RECOV: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // A grant overrides the RECOV -> IDLE step above.
      if (w_arbPoint && w_anyReq) begin
        r_state  <= S_SETUP;
        r_cnt    <= CW'(SETUP_CYC);
        r_busy   <= 1'b1;
        r_owner  <= w_pick1;
        r_rrPtr  <= ~w_pick1;
        r_isRead <= w_pick1 ? bus.rw1 : bus.rw0;
        r_upRw   <= w_pick1 ? bus.rw1 : bus.rw0;
        r_upAddr <= w_pick1 ? bus.addr1 : bus.addr0;
        r_wdata  <= w_pick1 ? bus.wdata1 : bus.wdata0;
      end
    end
  end

  assign uP_data     = r_dataOe ? r_wdata : 8'bz;
  assign bus.uP_addr = r_upAddr;
  assign bus.uP_rw   = r_upRw;
  assign bus.uP_cs_n = r_csN;
  assign bus.ack0    = r_ack0;
  assign bus.ack1    = r_ack1;
  assign bus.rdata   = r_rdata;
  assign bus.busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_up_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_up_bus_arbiter
// Purpose  : Bench for up_bus_arbiter: directed transfers, random traffic
//            against a phase-offset transfer model, and a minimum-timing
//            instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_up_bus_arbiter;
  localparam int S    = 2;
  localparam int O    = 1;
  localparam int C    = 5;
  localparam int H    = 1;
  localparam int R    = 2;
  localparam int T    = S + O + C + H + R;
  localparam int ACKC = S + O + C + H + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  up_bus_arbiter_if busA ();
  up_bus_arbiter_if busB ();
  wire [7:0] uPDataA;
  wire [7:0] uPDataB;

  logic       slvDrvA = 1'b0;
  logic [7:0] slvValA = 8'h00;
  int         slvMode = 0;
  int         csRunA  = 0;
  logic [7:0] mem [64];

  assign uPDataA = slvDrvA ? slvValA : 8'bz;
  assign uPDataB = (!busB.uP_cs_n && busB.uP_rw) ? 8'h5A : 8'bz;

  up_bus_arbiter #(.SETUP_CYC(S), .OE_CYC(O), .CS_CYC(C), .HOLD_CYC(H), .RECOV_CYC(R))
    dutA (.clk(clk), .rst(rst), .bus(busA), .uP_data(uPDataA));

  up_bus_arbiter #(.SETUP_CYC(1), .OE_CYC(1), .CS_CYC(1), .HOLD_CYC(1), .RECOV_CYC(1))
    dutB (.clk(clk), .rst(rst), .bus(busB), .uP_data(uPDataB));

  // Slave peripheral: returns mem[addr] while selected for a read. In mode 1
  // the correct byte is only presented on the last strobe cycle.
  always @(negedge clk) begin
    int n;
    n = busA.uP_cs_n ? 0 : csRunA + 1;
    csRunA  <= n;
    slvDrvA <= !busA.uP_cs_n && busA.uP_rw;
    slvValA <= (slvMode == 0 || n == C) ? mem[busA.uP_addr] : ~mem[busA.uP_addr];
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, actual, expected);
    end
  endtask

  // Transfer model: a transfer is a position c (1 = first cycle after the
  // accept edge) inside a fixed phase timeline.
  bit         mAct = 0;
  int         mC = 0;
  bit         mOwn = 0;
  bit         mPtr = 0;
  bit         mRw = 1;
  logic [5:0] mAddr = '0;
  logic [7:0] mWd = '0;
  logic [7:0] mRd = '0;

  // Observation counters used by the directed sections.
  int csLowCnt, oeCnt, dataA5Cnt, addrHitCnt, rwLowCnt;
  int ack0Cnt, ack1Cnt, busyRise, ackCyc, gapRun, lastGap;
  bit prevBusy = 0;
  int ackOrder[$];

  task automatic clrStats();
    csLowCnt = 0; oeCnt = 0; dataA5Cnt = 0; addrHitCnt = 0; rwLowCnt = 0;
    ack0Cnt = 0; ack1Cnt = 0; busyRise = -1; ackCyc = -1; lastGap = -1;
    ackOrder.delete();
  endtask

  // Model update on each edge, then every-cycle comparison of DUT A.
  always @(posedge clk) begin
    bit inAddr, expCs, expOe;
    bit q0, q1;
    q0 = busA.req0;
    q1 = busA.req1;
    if (rst) begin
      mAct = 0; mC = 0; mPtr = 0; mRd = '0;
    end else if ((!mAct || mC == T) && (q0 || q1)) begin
      mOwn  = (q0 && q1) ? mPtr : q1;
      mPtr  = !mOwn;
      mRw   = mOwn ? busA.rw1 : busA.rw0;
      mAddr = mOwn ? busA.addr1 : busA.addr0;
      mWd   = mOwn ? busA.wdata1 : busA.wdata0;
      mAct  = 1;
      mC    = 1;
    end else if (mAct) begin
      mC++;
      if (mC > T) mAct = 0;
    end
    if (mAct && mC == ACKC && mRw) mRd = mem[mAddr];
    cyc++;
    #1;
    inAddr = mAct && mC <= S + O + C + H;
    expCs  = !(mAct && mC >= S + O + 1 && mC <= S + O + C);
    expOe  = mAct && !mRw && mC >= S + 1 && mC <= S + O + C + H;
    chk("uP_addr", busA.uP_addr, inAddr ? mAddr : 0);
    chk("uP_rw",   busA.uP_rw,   inAddr ? mRw : 1);
    chk("uP_cs_n", busA.uP_cs_n, expCs);
    chk("data_oe", dutA.r_dataOe, expOe);
    if (expOe) chk("uP_data", uPDataA, mWd);
    chk("ack0",  busA.ack0, mAct && mC == ACKC && !mOwn);
    chk("ack1",  busA.ack1, mAct && mC == ACKC && mOwn);
    chk("busy",  busA.busy, mAct);
    chk("rdata", busA.rdata, mRd);
    // observation counters
    if (!busA.uP_cs_n) csLowCnt++;
    if (dutA.r_dataOe) begin
      oeCnt++;
      if (uPDataA == 8'hA5) dataA5Cnt++;
    end
    if (busA.uP_addr == 6'h15 && !busA.uP_rw) addrHitCnt++;
    if (!busA.uP_rw) rwLowCnt++;
    if (busA.ack0) begin ack0Cnt++; ackOrder.push_back(0); ackCyc = cyc; end
    if (busA.ack1) begin ack1Cnt++; ackOrder.push_back(1); ackCyc = cyc; end
    if (busA.busy && !prevBusy) busyRise = cyc;
    prevBusy = busA.busy;
    if (busA.uP_cs_n) gapRun++;
    else begin
      if (gapRun > 0) lastGap = gapRun;
      gapRun = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic waitAck(input int who, output bit ok);
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #3;
      if ((who == 0 && busA.ack0) || (who == 1 && busA.ack1)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("ack_timeout", 0, 1);
  endtask

  task automatic newReq(input int who);
    if (who == 0) begin
      busA.rw0 = 1'($urandom_range(0, 1)); busA.addr0 = 6'($urandom_range(0, 63));
      busA.wdata0 = 8'($urandom); busA.req0 = 1'b1;
    end else begin
      busA.rw1 = 1'($urandom_range(0, 1)); busA.addr1 = 6'($urandom_range(0, 63));
      busA.wdata1 = 8'($urandom); busA.req1 = 1'b1;
    end
  endtask

  // Random requester: holds req until its ack, then drops or re-requests.
  task automatic agent(input int who, input bit allowNew);
    bit r, a;
    r = (who == 0) ? busA.req0 : busA.req1;
    a = (who == 0) ? busA.ack0 : busA.ack1;
    if (r) begin
      if (a) begin
        if (allowNew && $urandom_range(0, 1) == 1) newReq(who);
        else if (who == 0) busA.req0 = 1'b0;
        else busA.req1 = 1'b0;
      end
    end else if (allowNew && $urandom_range(0, 3) == 0) begin
      newReq(who);
    end
  endtask

  initial begin
    bit ok;
    int n0, n1;
    int expOrd[4];
    int bRise, bAck, bCsLow, bAck1;
    expOrd = '{0, 1, 0, 1};
    busA.req0 = 0; busA.rw0 = 1; busA.addr0 = '0; busA.wdata0 = '0;
    busA.req1 = 0; busA.rw1 = 1; busA.addr1 = '0; busA.wdata1 = '0;
    busB.req0 = 0; busB.rw0 = 1; busB.addr0 = '0; busB.wdata0 = '0;
    busB.req1 = 0; busB.rw1 = 1; busB.addr1 = '0; busB.wdata1 = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[6'h2A] = 8'h3C;
    gapRun = 0;
    clrStats();

    tick(3); rst = 0; tick(1);
    chk("rst_addr",  busA.uP_addr, 0);
    chk("rst_rw",    busA.uP_rw, 1);
    chk("rst_cs_n",  busA.uP_cs_n, 1);
    chk("rst_busy",  busA.busy, 0);
    chk("rst_rdata", busA.rdata, 0);
    chk("rst_oe",    dutA.r_dataOe, 0);

    // Write from requester 0
    clrStats();
    busA.rw0 = 0; busA.addr0 = 6'h15; busA.wdata0 = 8'hA5; busA.req0 = 1;
    waitAck(0, ok);
    busA.req0 = 0;
    tick(4);
    chk("wr_addr_cycles", addrHitCnt, 9);
    chk("wr_cs_low",      csLowCnt, 5);
    chk("wr_oe_cycles",   oeCnt, 7);
    chk("wr_data_a5",     dataA5Cnt, 7);
    chk("wr_ack0",        ack0Cnt, 1);
    chk("wr_ack1",        ack1Cnt, 0);
    chk("wr_ack_latency", ackCyc - busyRise, 9);

    // Read from requester 1
    clrStats();
    busA.rw1 = 1; busA.addr1 = 6'h2A; busA.req1 = 1;
    waitAck(1, ok);
    chk("rd_rdata_ack", busA.rdata, 8'h3C);
    busA.req1 = 0;
    tick(5);
    chk("rd_rdata_held", busA.rdata, 8'h3C);
    chk("rd_oe_cycles",  oeCnt, 0);
    chk("rd_rw_low",     rwLowCnt, 0);
    chk("rd_ack1",       ack1Cnt, 1);
    chk("rd_ack0",       ack0Cnt, 0);

    // Simultaneous requests, two transfers each
    rst = 1; tick(1); rst = 0; tick(1);
    clrStats();
    busA.rw0 = 0; busA.addr0 = 6'h03; busA.wdata0 = 8'h11;
    busA.rw1 = 1; busA.addr1 = 6'h04;
    busA.req0 = 1; busA.req1 = 1;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 100 && (busA.req0 || busA.req1); k++) begin
      @(posedge clk); #3;
      if (busA.ack0) begin n0++; if (n0 == 2) busA.req0 = 0; end
      if (busA.ack1) begin n1++; if (n1 == 2) busA.req1 = 0; end
    end
    chk("rr_timeout", busA.req0 || busA.req1, 0);
    chk("rr_order_len", ackOrder.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < ackOrder.size()) chk("rr_order", ackOrder[i], expOrd[i]);
    tick(3);

    // Back-to-back writes from requester 0
    clrStats();
    busA.rw0 = 0; busA.addr0 = 6'h01; busA.wdata0 = 8'h5C; busA.req0 = 1;
    waitAck(0, ok);
    busA.addr0 = 6'h02; busA.wdata0 = 8'hC5;
    waitAck(0, ok);
    busA.req0 = 0;
    tick(3);
    chk("b2b_gap",  lastGap, 6);
    chk("b2b_acks", ack0Cnt, 2);

    // Reset during the third strobe cycle
    clrStats();
    busA.rw0 = 0; busA.addr0 = 6'h15; busA.wdata0 = 8'h77; busA.req0 = 1;
    for (int k = 0; k < 40 && csLowCnt < 3; k++) tick(1);
    chk("rst_mid_reach", csLowCnt, 3);
    rst = 1; busA.req0 = 0;
    tick(1);
    chk("rst_mid_cs_n", busA.uP_cs_n, 1);
    chk("rst_mid_oe",   dutA.r_dataOe, 0);
    chk("rst_mid_addr", busA.uP_addr, 0);
    chk("rst_mid_rw",   busA.uP_rw, 1);
    rst = 0;
    tick(15);
    chk("rst_mid_noack", ack0Cnt, 0);
    busA.req0 = 1;
    waitAck(0, ok);
    busA.req0 = 0;
    chk("rst_mid_after", ack0Cnt, 1);
    tick(4);

    // Random traffic with a tie-breaking slave and sparse resets
    slvMode = 1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #3;
      if (rst) rst = 0;
      else if ($urandom_range(0, 499) == 0) rst = 1;
      agent(0, 1'b1);
      agent(1, 1'b1);
    end
    rst = 0;
    for (int k = 0; k < 80 && (busA.req0 || busA.req1 || busA.busy); k++) begin
      @(posedge clk); #3;
      agent(0, 1'b0);
      agent(1, 1'b0);
    end
    chk("drain", busA.req0 || busA.req1 || busA.busy, 0);
    slvMode = 0;

    // Minimum-timing instance: single read
    bRise = -1; bAck = -1; bCsLow = 0; bAck1 = 0;
    busB.rw0 = 1; busB.addr0 = 6'h03; busB.req0 = 1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #3;
      if (busB.busy && bRise < 0) bRise = k;
      if (!busB.uP_cs_n) bCsLow++;
      if (busB.ack1) bAck1++;
      if (busB.ack0 && bAck < 0) begin
        bAck = k;
        chk("fast_rdata", busB.rdata, 8'h5A);
        busB.req0 = 0;
      end
    end
    chk("fast_ack_seen", bAck >= 0, 1);
    chk("fast_latency",  bAck - bRise, 4);
    chk("fast_cs_low",   bCsLow, 1);
    chk("fast_ack1",     bAck1, 0);
    chk("fast_rdata_held", busB.rdata, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/up_bus_arbiter.md
Name: up_bus_arbiter

Overview:
- Synthesizable clocked master for the 8-bit microprocessor peripheral bus: uP_data, uP_addr, uP_cs_n, uP_rw.
- Shares the bus between two on-chip requesters using round-robin arbitration.
- Sequences each transfer through the bus phases in clock cycles: address/rw setup, data enable, chip-select strobe, hold, recovery.
- Replaces the behavioural bus model wherever real hardware must drive the bus.

Parameters:
SETUP_CYC, 2, cycles addr/rw stable before data enable (min 1)
OE_CYC, 1, cycles write data driven before uP_cs_n falls (min 1)
CS_CYC, 5, cycles uP_cs_n held low (min 1)
HOLD_CYC, 1, cycles addr/rw/data held after uP_cs_n rises (min 1)
RECOV_CYC, 2, idle cycles between transfers (min 1)

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req0  in  1  requester 0 transfer request, level, held until ack0
rw0  in  1  requester 0 direction: 1 read, 0 write
addr0  in  6  requester 0 address
wdata0  in  8  requester 0 write data
ack0  out  1  one-cycle pulse: requester 0 transfer complete
req1/rw1/addr1/wdata1/ack1  same widths and meanings for requester 1
rdata  out  8  read data, valid in the ack cycle, held until the next read completes
busy  out  1  high in every state except IDLE
uP_data  inout  8  bus data, driven only while data_oe=1, else 8'bz
uP_addr  out  6  bus address
uP_cs_n  out  1  chip select, active-low
uP_rw  out  1  bus direction: 1 read, 0 write

Behaviour:
- All outputs registered.
- Reset values: uP_addr=0, uP_rw=1, uP_cs_n=1, data_oe=0 (uP_data=z), ack0=ack1=0, rdata=0, busy=0, state=IDLE, rr_ptr=0 (requester 0 has priority).
- Reset mid-transfer: at the next edge the bus returns to reset values, the transfer is abandoned, and no ack is issued.
- States: IDLE -> SETUP -> ENABLE -> STROBE -> HOLD -> RECOV -> IDLE. A per-state down-counter loads the state's parameter; the state advances when the counter reaches 1.
- IDLE:
  - With neither req asserted, stay in IDLE.
  - With one req asserted, grant that requester.
  - With both asserted, grant the requester selected by rr_ptr; after a grant, rr_ptr = the other requester.
  - On grant, latch rw/addr/wdata of the granted requester, go to SETUP, and drive uP_addr=addr, uP_rw=rw from the next cycle.
  - Requester inputs are ignored outside IDLE.
- SETUP: uP_cs_n=1, data_oe=0.
- ENABLE: data_oe=1 if the transfer is a write; reads keep data_oe=0.
- STROBE:
  - uP_cs_n=0.
  - On the final STROBE cycle edge, sample uP_data into an internal read register (reads only); uP_cs_n=1 from the next cycle.
- HOLD: uP_cs_n=1; addr, rw and data_oe unchanged.
- RECOV:
  - Entry edge: uP_addr=0, uP_rw=1, data_oe=0.
  - First RECOV cycle: ack of the granted requester=1; for reads, rdata=sampled value.
  - Ack lasts exactly one cycle.
- Transfer length with defaults: 1 accept edge + 2+1+5+1+2 = 11 cycles from accept to return to IDLE. The ack pulse appears 10 cycles after the accept edge (first RECOV cycle).
- A requester may hold req high through its ack; the arbiter re-arbitrates only in IDLE.
- Back-to-back: with the other requester idle, the same requester is granted again; the minimum gap between transfers (uP_cs_n high) is HOLD_CYC+RECOV_CYC+SETUP_CYC+OE_CYC cycles.
- No bus contention: data_oe is never 1 while uP_rw=1.
- data_oe changes only while uP_cs_n=1.

Test Plan:
- Write from req0 (addr 6'h15, wdata 8'hA5):
  - uP_addr=15 and uP_rw=0 for 9 cycles.
  - uP_data=A5 while data_oe is high (7 cycles).
  - uP_cs_n low for exactly 5 cycles.
  - ack0 one cycle; ack1 never.
- Read from req1 (addr 6'h2A), slave model drives 8'h3C while cs_n is low:
  - uP_rw=1 and uP_data never driven by the DUT.
  - rdata=3C in the ack1 cycle and held afterwards.
- req0 and req1 asserted on the same cycle, both held through two transfers:
  - Order is 0 then 1.
  - Repeated twice, the order is 0,1,0,1.
  - Recovery gap of 2 cycles before each IDLE.
- req0 held continuously, req1 idle: consecutive writes to 6'h01 and 6'h02, separated by exactly HOLD+RECOV+SETUP+OE = 6 cycles of uP_cs_n high.
- rst pulsed on the 3rd STROBE cycle of a write:
  - Next cycle: uP_cs_n=1, uP_data=z, uP_addr=0, uP_rw=1.
  - No ack.
  - A new req0 afterwards completes normally.
- Instance with SETUP_CYC=1, OE_CYC=1, CS_CYC=1, HOLD_CYC=1, RECOV_CYC=1: read transfer; uP_cs_n low for 1 cycle, ack 5 cycles after the accept edge, read data still captured correctly.
